// File: rtl/dma_axi_simple_csr_regs_if.sv
// CSR access bus between the write/read front-ends and the DMA register file.
// Carries both request/grant handshakes plus the write and read data paths.
interface dma_axi_simple_csr_regs_if #(parameter int ADDR_LENGTH = 8);
  logic                   TW_REQ;
  logic                   TW_GRT;
  logic [ADDR_LENGTH-1:0] TW_ADDR;
  logic                   TW_WREN;
  logic [31:0]            TW_WDATA;
  logic [3:0]             TW_WSTRB;
  logic                   TR_REQ;
  logic                   TR_GRT;
  logic [ADDR_LENGTH-1:0] TR_ADDR;
  logic                   TR_RDEN;
  logic [31:0]            TR_RDATA;

  modport master (
    output TW_REQ, TW_ADDR, TW_WREN, TW_WDATA, TW_WSTRB,
    output TR_REQ, TR_ADDR, TR_RDEN,
    input  TW_GRT, TR_GRT, TR_RDATA
  );

  modport slave (
    input  TW_REQ, TW_ADDR, TW_WREN, TW_WDATA, TW_WSTRB,
    input  TR_REQ, TR_ADDR, TR_RDEN,
    output TW_GRT, TR_GRT, TR_RDATA
  );
endinterface

// File: rtl/dma_axi_simple_csr_regs.sv
// Simple AXI DMA CSR file with write/read access arbiter, GO pulse, sticky DONE and IRQ.
// Optional macro DMA_CSR_PARAM_LOCK_EN: freezes SRC/DST/BNUM/CHUNK while DMA_BUSY=1.
module dma_axi_simple_csr_regs #(
  parameter int ADDR_LENGTH = 8
) (
  input  logic                       ARESETn,
  input  logic                       ACLK,
  dma_axi_simple_csr_regs_if.slave   csr,
  output logic                       DMA_EN,
  output logic                       DMA_GO,
  output logic [31:0]                DMA_SRC,
  output logic [31:0]                DMA_DST,
  output logic [15:0]                DMA_BNUM,
  output logic [7:0]                 DMA_CHUNK,
  input  logic                       DMA_BUSY,
  input  logic                       DMA_DONE,
  output logic                       IRQ
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WR = 2'd1, ST_RD = 2'd2} state_t;

  localparam logic [31:0] NAME    = 32'h444D_4120;
  localparam logic [31:0] VERSION = 32'h2015_0712;
  localparam logic [ADDR_LENGTH-1:0] A_NAME    = ADDR_LENGTH'(32'h00);
  localparam logic [ADDR_LENGTH-1:0] A_VERSION = ADDR_LENGTH'(32'h08);
  localparam logic [ADDR_LENGTH-1:0] A_CONTROL = ADDR_LENGTH'(32'h10);
  localparam logic [ADDR_LENGTH-1:0] A_START   = ADDR_LENGTH'(32'h30);
  localparam logic [ADDR_LENGTH-1:0] A_SRC     = ADDR_LENGTH'(32'h40);
  localparam logic [ADDR_LENGTH-1:0] A_DST     = ADDR_LENGTH'(32'h44);
  localparam logic [ADDR_LENGTH-1:0] A_BNUM    = ADDR_LENGTH'(32'h48);
  localparam logic [ADDR_LENGTH-1:0] A_CHUNK   = ADDR_LENGTH'(32'h4C);
  localparam logic [ADDR_LENGTH-1:0] A_WMASK   = ~ADDR_LENGTH'(32'h3);

  state_t      r_state;
  logic        r_last_wr;
  logic        r_tw_grt;
  logic        r_tr_grt;
  logic        r_en;
  logic        r_ie;
  logic        r_ip;
  logic        r_done;
  logic        r_go;
  logic        r_irq;
  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [15:0] r_bnum;
  logic [7:0]  r_chunk;
  logic [31:0] r_rdata;

  logic [ADDR_LENGTH-1:0] w_waddr;
  logic [ADDR_LENGTH-1:0] w_raddr;
  logic        w_wr;
  logic [31:0] w_bmask;
  logic [31:0] w_wdata;
  logic        w_wr_ctrl;
  logic        w_wr_start;
  logic        w_param_ok;
  logic        w_go_acc;
  logic        w_ie_nxt;
  logic        w_ip_nxt;
  logic [31:0] w_rdata;

  assign w_waddr    = csr.TW_ADDR & A_WMASK;
  assign w_raddr    = csr.TR_ADDR & A_WMASK;
  assign w_wr       = r_tw_grt & csr.TW_WREN;
  assign w_wdata    = csr.TW_WDATA;
  assign w_bmask    = {{8{csr.TW_WSTRB[3]}}, {8{csr.TW_WSTRB[2]}},
                       {8{csr.TW_WSTRB[1]}}, {8{csr.TW_WSTRB[0]}}};
  assign w_wr_ctrl  = w_wr && (w_waddr == A_CONTROL);
  assign w_wr_start = w_wr && (w_waddr == A_START);
`ifdef DMA_CSR_PARAM_LOCK_EN
  assign w_param_ok = ~DMA_BUSY;
`else
  assign w_param_ok = 1'b1;
`endif

  // IRQ is registered from next-state IP/IE so it tracks IP with no extra cycle of lag
  always_comb begin
    w_go_acc = w_wr_start & csr.TW_WSTRB[3] & w_wdata[31] & r_en & ~DMA_BUSY;
    w_ie_nxt = r_ie;
    if (w_wr_ctrl && csr.TW_WSTRB[0]) w_ie_nxt = w_wdata[1];
    w_ip_nxt = r_ip;
    if (w_wr_ctrl && csr.TW_WSTRB[0] && w_wdata[0]) w_ip_nxt = 1'b0;
    if (DMA_DONE && r_ie) w_ip_nxt = 1'b1;
  end

  always_comb begin
    w_rdata = '0;
    case (w_raddr)
      A_NAME:    w_rdata = NAME;
      A_VERSION: w_rdata = VERSION;
      A_CONTROL: w_rdata = {r_en, 29'd0, r_ie, r_ip};
      A_START:   w_rdata = {DMA_BUSY, 30'd0, r_done};
      A_SRC:     w_rdata = r_src;
      A_DST:     w_rdata = r_dst;
      A_BNUM:    w_rdata = {16'd0, r_bnum};
      A_CHUNK:   w_rdata = {24'd0, r_chunk};
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= ST_IDLE;
      r_last_wr <= 1'b0;
      r_tw_grt  <= 1'b0;
      r_tr_grt  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (csr.TW_REQ && (!csr.TR_REQ || !r_last_wr)) begin
            r_state   <= ST_WR;
            r_tw_grt  <= 1'b1;
            r_last_wr <= 1'b1;
          end else if (csr.TR_REQ) begin
            r_state   <= ST_RD;
            r_tr_grt  <= 1'b1;
            r_last_wr <= 1'b0;
          end
        end
        ST_WR: if (!csr.TW_REQ) begin
          r_state  <= ST_IDLE;
          r_tw_grt <= 1'b0;
        end
        ST_RD: if (!csr.TR_REQ) begin
          r_state  <= ST_IDLE;
          r_tr_grt <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_tw_grt <= 1'b0;
          r_tr_grt <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_en    <= 1'b0;
      r_ie    <= 1'b0;
      r_ip    <= 1'b0;
      r_done  <= 1'b0;
      r_go    <= 1'b0;
      r_irq   <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_bnum  <= '0;
      r_chunk <= '0;
      r_rdata <= '0;
    end else begin
      r_go  <= w_go_acc;
      r_ie  <= w_ie_nxt;
      r_ip  <= w_ip_nxt;
      r_irq <= w_ip_nxt & w_ie_nxt;
      if (w_wr_ctrl && csr.TW_WSTRB[3]) r_en <= w_wdata[31];
      // completion and start in one cycle: DONE ends up set
      if (DMA_DONE) r_done <= 1'b1;
      else if (w_go_acc) r_done <= 1'b0;
      if (w_wr && w_param_ok) begin
        if (w_waddr == A_SRC)   r_src   <= (r_src & ~w_bmask) | (w_wdata & w_bmask);
        if (w_waddr == A_DST)   r_dst   <= (r_dst & ~w_bmask) | (w_wdata & w_bmask);
        if (w_waddr == A_BNUM)  r_bnum  <= (r_bnum & ~w_bmask[15:0]) | (w_wdata[15:0] & w_bmask[15:0]);
        if (w_waddr == A_CHUNK) r_chunk <= (r_chunk & ~w_bmask[7:0]) | (w_wdata[7:0] & w_bmask[7:0]);
      end
      if (r_tr_grt && csr.TR_RDEN) r_rdata <= w_rdata;
    end
  end

  assign csr.TW_GRT   = r_tw_grt;
  assign csr.TR_GRT   = r_tr_grt;
  assign csr.TR_RDATA = r_rdata;
  assign DMA_EN       = r_en;
  assign DMA_GO       = r_go;
  assign DMA_SRC      = r_src;
  assign DMA_DST      = r_dst;
  assign DMA_BNUM     = r_bnum;
  assign DMA_CHUNK    = r_chunk;
  assign IRQ          = r_irq;
endmodule

// File: tb/tb_dma_axi_simple_csr_regs.sv
// Self-checking bench for dma_axi_simple_csr_regs: directed plan steps plus random
// CSR traffic checked against a register-map reference model.
module tb_dma_axi_simple_csr_regs;
  localparam int AL = 8;
`ifdef DMA_CSR_PARAM_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  dma_axi_simple_csr_regs_if #(.ADDR_LENGTH(AL)) bus ();
  logic        dma_en, dma_go, dma_busy, dma_done, irq;
  logic [31:0] dma_src, dma_dst;
  logic [15:0] dma_bnum;
  logic [7:0]  dma_chunk;

  dma_axi_simple_csr_regs #(.ADDR_LENGTH(AL)) dut (
    .ARESETn(ARESETn), .ACLK(ACLK), .csr(bus),
    .DMA_EN(dma_en), .DMA_GO(dma_go), .DMA_SRC(dma_src), .DMA_DST(dma_dst),
    .DMA_BNUM(dma_bnum), .DMA_CHUNK(dma_chunk), .DMA_BUSY(dma_busy),
    .DMA_DONE(dma_done), .IRQ(irq)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  // reference model: RW field storage per word plus the special status bits
  logic [31:0] m_word [0:63];
  logic        m_ip, m_done;
  logic [31:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] rw_mask(input logic [7:0] a);
    case (a)
      8'h10:        return 32'h8000_0002;
      8'h40, 8'h44: return 32'hFFFF_FFFF;
      8'h48:        return 32'h0000_FFFF;
      8'h4C:        return 32'h0000_00FF;
      default:      return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] addr);
    logic [7:0] a;
    a = addr & 8'hFC;
    case (a)
      8'h00:   return 32'h444D_4120;
      8'h08:   return 32'h2015_0712;
      8'h10:   return m_word[4] | {31'd0, m_ip};
      8'h30:   return {dma_busy, 30'd0, m_done};
      default: return m_word[a >> 2];
    endcase
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 64; i++) m_word[i] = '0;
    m_ip = 1'b0; m_done = 1'b0; m_rdata = '0;
  endtask

  task automatic model_done(input logic ie);
    m_done = 1'b1;
    if (ie) m_ip = 1'b1;
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic done_same, output logic go);
    logic [7:0]  a;
    logic [31:0] bm, m;
    logic        old_ie, lock;
    a      = addr & 8'hFC;
    bm     = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    old_ie = m_word[4][1];
    lock   = LOCK_EN && dma_busy && (a >= 8'h40);
    go     = (a == 8'h30) && strb[3] && data[31] && m_word[4][31] && !dma_busy;
    m      = bm & rw_mask(a);
    if (!lock) m_word[a >> 2] = (m_word[a >> 2] & ~m) | (data & m);
    if (go) m_done = 1'b0;
    if (a == 8'h10 && strb[0] && data[0]) m_ip = 1'b0;
    if (done_same) model_done(old_ie);
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_en"},    {31'd0, dma_en}, {31'd0, m_word[4][31]});
    check({tag, "_src"},   dma_src, m_word[16]);
    check({tag, "_dst"},   dma_dst, m_word[17]);
    check({tag, "_bnum"},  {16'd0, dma_bnum}, {16'd0, m_word[18][15:0]});
    check({tag, "_chunk"}, {24'd0, dma_chunk}, {24'd0, m_word[19][7:0]});
    check({tag, "_irq"},   {31'd0, irq}, {31'd0, m_ip & m_word[4][1]});
  endtask

  task automatic wait_wgrant;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.TW_GRT) break;
    end
    check("tw_grant", {31'd0, bus.TW_GRT}, 32'd1);
  endtask

  task automatic wait_rgrant;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.TR_GRT) break;
    end
    check("tr_grant", {31'd0, bus.TR_GRT}, 32'd1);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic done_same);
    logic exp_go;
    bus.TW_REQ = 1'b1;
    wait_wgrant();
    bus.TW_ADDR = addr; bus.TW_WDATA = data; bus.TW_WSTRB = strb; bus.TW_WREN = 1'b1;
    dma_done = done_same;
    model_write(addr, data, strb, done_same, exp_go);
    tick;
    bus.TW_WREN = 1'b0; dma_done = 1'b0;
    check("go_pulse", {31'd0, dma_go}, {31'd0, exp_go});
    check_outs("wr");
    bus.TW_REQ = 1'b0;
    tick;
    check("go_end", {31'd0, dma_go}, 32'd0);
    check("tw_release", {31'd0, bus.TW_GRT}, 32'd0);
  endtask

  task automatic rd(input logic [7:0] addr);
    bus.TR_REQ = 1'b1;
    wait_rgrant();
    bus.TR_ADDR = addr; bus.TR_RDEN = 1'b1;
    m_rdata = model_read(addr);
    tick;
    bus.TR_RDEN = 1'b0;
    check("rdata", bus.TR_RDATA, m_rdata);
    bus.TR_REQ = 1'b0;
    tick;
  endtask

  task automatic pulse_done;
    dma_done = 1'b1;
    model_done(m_word[4][1]);
    tick;
    dma_done = 1'b0;
    check("done_irq", {31'd0, irq}, {31'd0, m_ip & m_word[4][1]});
  endtask

  logic [7:0] addr_tbl [0:11];
  logic       gx;

  initial begin
    addr_tbl = '{8'h00, 8'h08, 8'h10, 8'h30, 8'h40, 8'h44, 8'h48, 8'h4C,
                 8'h20, 8'h50, 8'h84, 8'hFC};
    bus.TW_REQ = 0; bus.TW_ADDR = 0; bus.TW_WREN = 0; bus.TW_WDATA = 0; bus.TW_WSTRB = 0;
    bus.TR_REQ = 0; bus.TR_ADDR = 0; bus.TR_RDEN = 0;
    dma_busy = 0; dma_done = 0;
    model_reset();
    tick; tick;
    check("rst_rdata", bus.TR_RDATA, 32'd0);
    check("rst_grts", {30'd0, bus.TW_GRT, bus.TR_GRT}, 32'd0);
    check("rst_go", {31'd0, dma_go}, 32'd0);
    check_outs("rst");
    ARESETn = 1'b1;
    tick;

    // arbitration: write first, then read, then write again
    bus.TW_REQ = 1; bus.TR_REQ = 1;
    tick;
    check("arb1", {30'd0, bus.TW_GRT, bus.TR_GRT}, 32'b10);
    bus.TW_REQ = 0;
    tick;
    check("arb_rel", {30'd0, bus.TW_GRT, bus.TR_GRT}, 32'b00);
    bus.TW_REQ = 1; bus.TR_ADDR = 8'h00; bus.TR_RDEN = 1;
    tick;
    bus.TR_RDEN = 0;
    check("arb2", {30'd0, bus.TW_GRT, bus.TR_GRT}, 32'b01);
    check("ungranted_rd", bus.TR_RDATA, 32'd0);
    bus.TW_ADDR = 8'h40; bus.TW_WDATA = 32'hDEAD_BEEF; bus.TW_WSTRB = 4'hF; bus.TW_WREN = 1;
    tick;
    bus.TW_WREN = 0;
    check("ungranted_wr", dma_src, 32'd0);
    bus.TW_REQ = 0; bus.TR_REQ = 0;
    tick;
    bus.TW_REQ = 1; bus.TR_REQ = 1;
    tick;
    check("arb3", {30'd0, bus.TW_GRT, bus.TR_GRT}, 32'b10);
    bus.TW_REQ = 0; bus.TR_REQ = 0;
    tick; tick;

    rd(8'h00);
    check("name", bus.TR_RDATA, 32'h444D_4120);
    rd(8'h08);
    check("version", bus.TR_RDATA, 32'h2015_0712);
    rd(8'h44);

    wr(8'h40, 32'h1234_5678, 4'b0011, 1'b0);
    rd(8'h40);
    check("src_partial", bus.TR_RDATA, 32'h0000_5678);
    check("src_out", dma_src, 32'h0000_5678);

    wr(8'h10, 32'h8000_0002, 4'hF, 1'b0);
    wr(8'h30, 32'h8000_0000, 4'hF, 1'b0);
    dma_busy = 1;
    wr(8'h30, 32'h8000_0000, 4'hF, 1'b0);
    rd(8'h30);
    dma_busy = 0;

    pulse_done();
    rd(8'h30);
    check("irq_set", {31'd0, irq}, 32'd1);
    wr(8'h10, 32'h8000_0003, 4'hF, 1'b1);
    check("ip_set_wins", {31'd0, irq}, 32'd1);
    wr(8'h10, 32'h8000_0003, 4'hF, 1'b0);
    check("irq_clr", {31'd0, irq}, 32'd0);

    dma_busy = 1;
    wr(8'h44, 32'hA000_0000, 4'hF, 1'b0);
    rd(8'h44);
    dma_busy = 0;

    // back-to-back writes inside one grant
    bus.TW_REQ = 1;
    wait_wgrant();
    for (int i = 0; i < 3; i++) begin
      bus.TW_ADDR = 8'h44 + 8'(4 * i); bus.TW_WDATA = $urandom; bus.TW_WSTRB = 4'hF;
      bus.TW_WREN = 1;
      model_write(bus.TW_ADDR, bus.TW_WDATA, 4'hF, 1'b0, gx);
      tick;
    end
    bus.TW_WREN = 0; bus.TW_REQ = 0;
    check_outs("b2b");
    tick;

    for (int n = 0; n < 80; n++) begin
      logic [7:0] a;
      a = addr_tbl[$urandom_range(0, 11)] | 8'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0, 1: wr(a, $urandom, 4'($urandom), 1'($urandom_range(0, 3) == 0));
        2:    rd(a);
        3:    pulse_done();
        default: begin dma_busy = 1'($urandom); tick; end
      endcase
    end
    dma_busy = 0;

    // reset while a GO pulse is in flight
    wr(8'h10, 32'h8000_0002, 4'hF, 1'b0);
    bus.TW_REQ = 1;
    wait_wgrant();
    bus.TW_ADDR = 8'h30; bus.TW_WDATA = 32'h8000_0000; bus.TW_WSTRB = 4'hF; bus.TW_WREN = 1;
    tick;
    bus.TW_WREN = 0; bus.TW_REQ = 0;
    check("go_before_rst", {31'd0, dma_go}, 32'd1);
    ARESETn = 0;
    #1;
    model_reset();
    check("rst_mid_go", {31'd0, dma_go}, 32'd0);
    check("rst_mid_grt", {31'd0, bus.TW_GRT}, 32'd0);
    check("rst_mid_rdata", bus.TR_RDATA, 32'd0);
    check_outs("rst_mid");
    tick;
    ARESETn = 1;
    tick;
    rd(8'h10);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dma_axi_simple_csr_regs.md
# dma_axi_simple_csr_regs

Control/status register file and access arbiter for the simple AXI DMA. It sits directly downstream of the CSR write front-end (TW_* port) and its read counterpart (TR_* port). It grants exclusive access to one of them at a time and holds the DMA configuration registers. It drives the start/parameter interface of the DMA engine and collects its completion into a sticky status and an interrupt.

## Interface
- ADDR_LENGTH, 8, CSR byte-address width (256-byte window)
- ARESETn  in  1  asynchronous active-low reset
- ACLK  in  1  clock; every register is rising-edge
- TW_REQ  in  1  write-side access request
- TW_GRT  out  1  write-side grant
- TW_ADDR  in  ADDR_LENGTH  word-aligned write address
- TW_WREN  in  1  write strobe, one cycle per word
- TW_WDATA  in  32  write data
- TW_WSTRB  in  4  byte enables
- TR_REQ  in  1  read-side access request
- TR_GRT  out  1  read-side grant
- TR_ADDR  in  ADDR_LENGTH  word-aligned read address
- TR_RDEN  in  1  read strobe
- TR_RDATA  out  32  read data
- DMA_EN, DMA_GO  out  1 each  engine enable; one-cycle start pulse
- DMA_SRC, DMA_DST  out  32 each  source and destination byte addresses
- DMA_BNUM  out  16  transfer length in bytes
- DMA_CHUNK  out  8  burst chunk size in bytes
- DMA_BUSY  in  1  engine busy level
- DMA_DONE  in  1  engine completion pulse
- IRQ  out  1  level interrupt

## Operation
- Register map (byte offset):
  - 0x00 NAME RO 0x444D4120
  - 0x08 VERSION RO 0x20150712
  - 0x10 CONTROL: [31] EN RW, [1] IE RW, [0] IP write-1-to-clear
  - 0x30 START: [31] GO (write 1 to start; reads DMA_BUSY), [0] DONE RO sticky
  - 0x40 SRC RW, 0x44 DST RW, 0x48 BNUM[15:0] RW, 0x4C CHUNK[7:0] RW
- Unmapped addresses read 0x0; writes to them are ignored. Writes to RO fields are ignored.
- RW fields update per byte lane under TW_WSTRB. A GO or W1C bit takes effect only when its byte lane is enabled.
- Address bits [1:0] are ignored.
- Arbiter FSM, states ST_IDLE, ST_WR, ST_RD:
  - ST_IDLE, TW_REQ only: go to ST_WR.
  - ST_IDLE, TR_REQ only: go to ST_RD.
  - ST_IDLE, both requests: grant the side not served last. After reset, write wins.
  - ST_WR: stay while TW_REQ=1; return to ST_IDLE when TW_REQ=0.
  - ST_RD: same rule with TR_REQ.
- TW_GRT=1 exactly in ST_WR; TR_GRT=1 exactly in ST_RD.
- TW_WREN is honoured only when TW_GRT=1; TR_RDEN only when TR_GRT=1. Ungranted strobes have no effect.
- GO write:
  - Accepted only when EN=1 and DMA_BUSY=0, otherwise dropped silently.
  - On accept: DMA_GO pulses for one cycle and DONE clears.
- DMA_DONE=1:
  - Sets DONE.
  - Sets IP if IE=1.
  - If a W1C of IP lands in the same cycle, the set wins.
- IRQ = IP & IE, registered.
- DMA_EN, DMA_SRC, DMA_DST, DMA_BNUM and DMA_CHUNK are direct outputs of their registers.

## Timing
- Reset value of every output and register is 0, including TR_RDATA, both grants, IRQ and DMA_GO. NAME and VERSION are constants.
- Grant latency: a request sampled at edge N gives GRT high after edge N. Release: REQ low at edge M gives GRT low after edge M.
- Write latency: a register updates at the edge sampling TW_WREN=1. DMA_GO is high for the following cycle only.
- Read latency: TR_RDATA is loaded at the edge sampling TR_RDEN=1. It holds until the next granted read.
- Back-to-back TW_WREN on consecutive cycles: every write is applied.
- Reset mid-operation clears everything, including a pending DMA_GO, and returns the FSM to ST_IDLE.

## Configuration
- DMA_CSR_PARAM_LOCK_EN:
  - Defined: writes to SRC, DST, BNUM and CHUNK are ignored while DMA_BUSY=1. CONTROL and START remain writable.
  - Undefined: those writes are always applied. The engine relies on latching its parameters at DMA_GO.

## Test plan
- Reset, then read 0x00 and 0x08 -> TR_RDATA 0x444D4120 and 0x20150712; read 0x44 -> 0x0.
- Write 0x40=0x12345678 with WSTRB=4'b0011 over an initial 0x0 -> read 0x00005678; DMA_SRC equals the same value.
- Write CONTROL=0x80000002, then START=0x80000000 -> DMA_GO is high for exactly one cycle. With DMA_BUSY=1, a second GO produces no pulse.
- Pulse DMA_DONE with IE=1 -> START reads 0x1 and IRQ=1. Writing CONTROL=0x80000003 in the same cycle as a second DONE pulse leaves IP=1. A later write of 0x80000003 clears IRQ.
- Assert TW_REQ and TR_REQ together from reset -> write granted first. When both request again after release, read is granted; TR_RDEN while ungranted returns no update.
- With DMA_CSR_PARAM_LOCK_EN defined and DMA_BUSY=1, write DST=0xA0000000 -> DST unchanged. Without the macro -> DST=0xA0000000.
